// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one dff write port among N requesters, with bounded lock bursts.
// Latency: one cycle from req/wdata sampled at a posedge to gnt/dff_d/dff_en registered.
// Backpressure: requesters hold req until they see gnt; a locked owner keeps the port for at most MAX_HOLD grants.
//
// Ports:
//   clk     system clock, all state changes on posedge
//   rst     synchronous active-low reset
//   req     per-requester write request (level)
//   lock    per-requester burst lock, only honoured for the current owner
//   wdata   packed requester data, slice i = wdata[i*size +: size]
//   gnt     registered one-hot grant, zero when idle
//   dff_d   registered data to the shared dff
//   dff_en  registered write enable to the shared dff (equals |gnt)
//   owner   index of the granted requester, valid while dff_en=1
module reg_write_arbiter #(
    parameter int size     = 8,
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         lock,
    input  logic [N*size-1:0]    wdata,
    output logic [N-1:0]         gnt,
    output logic [size-1:0]      dff_d,
    output logic                 dff_en,
    output logic [$clog2(N)-1:0] owner
);

    localparam int OW = $clog2(N);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state;
    logic [OW-1:0]   last;
    logic [CW-1:0]   hold_cnt;

    logic [OW-1:0]   cand;
    logic [OW-1:0]   win;
    logic            any;
    logic            keep;

    // Rotating-priority search starting just after the last winner. During a
    // burst, last is the owner, so a released owner automatically drops to
    // lowest priority.
    always_comb begin
        cand = '0;
        win  = last;
        any  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = OW'((int'(last) + k) % N);
            if (!any && req[cand]) begin
                any = 1'b1;
                win = cand;
            end
        end
    end

    // Burst continues only while the owner still requests, still locks, and
    // has grants left.
    assign keep = (state == HOLD) && req[last] && lock[last] &&
                  (hold_cnt < CW'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            last     <= OW'(N - 1);
            hold_cnt <= '0;
            gnt      <= '0;
            dff_d    <= '0;
            dff_en   <= 1'b0;
            owner    <= '0;
        end else if (keep) begin
            gnt      <= ONE << last;
            dff_d    <= wdata[last*size +: size];
            dff_en   <= 1'b1;
            owner    <= last;
            hold_cnt <= hold_cnt + 1'b1;
        end else if (any) begin
            // Fresh arbitration, also used when a burst ends so no bubble is inserted.
            gnt      <= ONE << win;
            dff_d    <= wdata[win*size +: size];
            dff_en   <= 1'b1;
            owner    <= win;
            last     <= win;
            hold_cnt <= CW'(1);
            state    <= lock[win] ? HOLD : IDLE;
        end else begin
            // Idle: dff_d and owner keep their last values.
            gnt      <= '0;
            dff_en   <= 1'b0;
            state    <= IDLE;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

    localparam int SIZE = 8;
    localparam int N    = 4;
    localparam int MAXH = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N*SIZE-1:0] wdata;
    logic [N-1:0]    gnt;
    logic [SIZE-1:0] dff_d;
    logic            dff_en;
    logic [1:0]      owner;

    reg_write_arbiter #(.size(SIZE), .N(N), .MAX_HOLD(MAXH)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .lock   (lock),
        .wdata  (wdata),
        .gnt    (gnt),
        .dff_d  (dff_d),
        .dff_en (dff_en),
        .owner  (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic       en;
        logic [7:0] d;
        logic [1:0] own;
    } exp_t;

    exp_t exp_q[$];
    int   ncmp = 0;
    int   nerr = 0;

    // Reference state for the random phase.
    logic [1:0] m_last;
    logic       m_hold;
    int         m_cnt;
    logic [3:0] m_gnt;
    logic       m_en;
    logic [7:0] m_d;
    logic [1:0] m_own;

    localparam logic [31:0] WD_FIX = {8'h13, 8'h12, 8'h11, 8'h10};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic compare_pending();
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gnt", 32'(gnt), 32'(e.gnt));
            chk("dff_en", 32'(dff_en), 32'(e.en));
            chk("dff_d", 32'(dff_d), 32'(e.d));
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (e.en) chk("owner", 32'(owner), 32'(e.own));
        end
    endtask

    // Model of one posedge given the inputs being driven.
    task automatic model_step(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                              input logic [31:0] wd);
        logic       found;
        logic [1:0] w;
        if (!r) begin
            m_last = 2'd3; m_hold = 1'b0; m_cnt = 0;
            m_gnt = 4'd0; m_en = 1'b0; m_d = 8'h00; m_own = 2'd0;
        end else if (m_hold && rq[m_last] && lk[m_last] && m_cnt < MAXH) begin
            m_gnt = 4'd0; m_gnt[m_last] = 1'b1;
            m_en = 1'b1; m_d = wd[m_last*8 +: 8]; m_own = m_last;
            m_cnt++;
        end else begin
            found = 1'b0; w = 2'd0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && rq[(int'(m_last) + k) % 4]) begin
                    found = 1'b1;
                    w = 2'((int'(m_last) + k) % 4);
                end
            end
            if (found) begin
                m_gnt = 4'd0; m_gnt[w] = 1'b1;
                m_en = 1'b1; m_d = wd[w*8 +: 8]; m_own = w;
                m_last = w; m_cnt = 1; m_hold = lk[w];
            end else begin
                m_gnt = 4'd0; m_en = 1'b0; m_hold = 1'b0;
            end
        end
    endtask

    // One cycle: check last cycle's output, drive new inputs on negedge,
    // push the expectation for the next cycle (hand-written when hand=1).
    task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                       input logic [31:0] wd, input logic hand,
                       input logic [3:0] hg, input logic [7:0] hd);
        exp_t e;
        @(negedge clk);
        compare_pending();
        rst = r; req = rq; lock = lk; wdata = wd;
        model_step(r, rq, lk, wd);
        if (hand) begin
            e.gnt = hg; e.en = |hg; e.d = hd; e.own = idx_of(hg);
        end else begin
            e.gnt = m_gnt; e.en = m_en; e.d = m_d; e.own = m_own;
        end
        exp_q.push_back(e);
    endtask

    task automatic h(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                     input logic [3:0] g, input logic [7:0] d);
        cyc(r, rq, lk, WD_FIX, 1'b1, g, d);
    endtask

    initial begin
        rst = 1'b0; req = 4'b1111; lock = 4'd0; wdata = WD_FIX;
        model_step(1'b0, 4'd0, 4'd0, WD_FIX);

        // Reset held with all requests pending.
        repeat (3) h(1'b0, 4'b1111, 4'b0000, 4'b0000, 8'h00);

        // Plain round robin.
        h(1'b1, 4'b1111, 4'b0000, 4'b0001, 8'h10);
        h(1'b1, 4'b1111, 4'b0000, 4'b0010, 8'h11);
        h(1'b1, 4'b1111, 4'b0000, 4'b0100, 8'h12);
        h(1'b1, 4'b1111, 4'b0000, 4'b1000, 8'h13);
        h(1'b1, 4'b1111, 4'b0000, 4'b0001, 8'h10);
        h(1'b1, 4'b1111, 4'b0000, 4'b0010, 8'h11);
        h(1'b1, 4'b1111, 4'b0000, 4'b0100, 8'h12);

        // Idle: data holds.
        h(1'b1, 4'b0000, 4'b0000, 4'b0000, 8'h12);
        h(1'b1, 4'b0000, 4'b0000, 4'b0000, 8'h12);

        // Bounded bursts by requester 1.
        h(1'b1, 4'b0011, 4'b0010, 4'b0001, 8'h10);
        repeat (4) h(1'b1, 4'b0011, 4'b0010, 4'b0010, 8'h11);
        h(1'b1, 4'b0011, 4'b0010, 4'b0001, 8'h10);
        repeat (4) h(1'b1, 4'b0011, 4'b0010, 4'b0010, 8'h11);
        h(1'b1, 4'b0011, 4'b0010, 4'b0001, 8'h10);
        h(1'b1, 4'b0011, 4'b0010, 4'b0010, 8'h11);
        h(1'b1, 4'b0011, 4'b0010, 4'b0010, 8'h11);

        // Reset in the second burst cycle.
        h(1'b0, 4'b0011, 4'b0010, 4'b0000, 8'h00);
        h(1'b1, 4'b0011, 4'b0010, 4'b0001, 8'h10);
        h(1'b1, 4'b0011, 4'b0010, 4'b0010, 8'h11);

        // Foreign lock only counts once requester 2 wins.
        h(1'b0, 4'b0000, 4'b0000, 4'b0000, 8'h00);
        h(1'b1, 4'b0101, 4'b0100, 4'b0001, 8'h10);
        repeat (4) h(1'b1, 4'b0101, 4'b0100, 4'b0100, 8'h12);
        h(1'b1, 4'b0101, 4'b0100, 4'b0001, 8'h10);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 40) != 0), 4'($urandom), 4'($urandom),
                $urandom, 1'b0, 4'd0, 8'd0);
        end

        @(negedge clk);
        compare_pending();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter that shares the write port of one `dff` register among `N` requesters. It drives the register's `d` and `en` inputs and returns a one-hot grant to the winning requester. An optional lock lets a requester hold the port for a bounded burst of back-to-back writes. It sits between the pipeline/CSR write sources and a shared `dff#(size)` instance.

## Interface
- `size`, 8, data width; matches the attached `dff#(size)`.
- `N`, 4, number of requesters (≥2).
- `MAX_HOLD`, 4, maximum consecutive grants to one requester in a locked burst (≥1).

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  reset; synchronous, active-low (`rst=0` resets on the next posedge).
- `req`  in  N  per-requester write request; level.
- `lock`  in  N  per-requester burst lock; meaningful only for the current owner.
- `wdata`  in  N*size  requester data; slice i = `wdata[i*size +: size]`.
- `gnt`  out  N  one-hot grant, registered; all zero when idle.
- `dff_d`  out  size  to `dff.d`, registered.
- `dff_en`  out  1  to `dff.en`, registered; equals `|gnt`.
- `owner`  out  $clog2(N)  index of the granted requester; valid when `dff_en=1`.

## Operation
- Internal state:
  - `last`: last granted index, reset to N-1 so the first search starts at 0.
  - FSM state: IDLE or HOLD.
  - `hold_cnt`: grants issued in the current burst, including the first.
- Arbitration: search `req` starting at `(last+1) mod N` and wrap around; the first set bit wins (`w`).
- IDLE, any `req` set:
  - Register `gnt=onehot(w)`, `dff_en=1`, `dff_d=wdata[w]`, `owner=w`, `last=w`, `hold_cnt=1`.
  - If `lock[w]=1` at the same edge, go to HOLD; otherwise stay in IDLE.
- IDLE, no `req`: `gnt=0`, `dff_en=0`. `dff_d` and `owner` hold their previous values.
- HOLD, owner `w`:
  - If `req[w] && lock[w] && hold_cnt<MAX_HOLD`: re-grant `w`, reload `dff_d=wdata[w]`, increment `hold_cnt`.
  - Otherwise: release the burst and re-arbitrate at the same edge (no bubble) from `w+1`, so `w` has lowest priority. The outcome follows the IDLE rules; the new winner may enter HOLD.
- Lock from a non-owner is ignored until that requester wins arbitration.
- With `lock` tied to 0, the FSM never leaves IDLE and the block is a plain round-robin arbiter.
- Reset sets `gnt=0`, `dff_en=0`, `dff_d=0`, `owner=0`, `last=N-1`, state IDLE, `hold_cnt=0`. Reset overrides every other event, including mid-burst.

## Timing
- Latency is one cycle.
  - `req`/`wdata` sampled at posedge k drive `gnt`/`dff_en`/`dff_d` during cycle k+1.
  - The `dff` captures `dff_d` at posedge k+1.
- Requesters see `gnt` in cycle k+1 and may drop `req` then. The write has already been committed at that point.
- `wdata[w]` is sampled only at the edge where `w` wins or is re-granted; changes between those edges are ignored.
- At most one `gnt` bit is set in any cycle.
- A burst occupies exactly `min(MAX_HOLD, cycles lock held)` consecutive grants.
- Outputs change only on posedge; there are no combinational paths from inputs to outputs.
- Drive inputs on the negedge in benches, as for the `dff`.

## Test plan
- Reset hold: `rst=0` for 3 cycles with `req=4'b1111` → `gnt=0`, `dff_en=0`, `dff_d=8'h00` every cycle. The first grant after release is `4'b0001`.
- Round robin: `req=4'b1111`, `lock=0`, `wdata[i]=8'h10+i` → `gnt` = 0001, 0010, 0100, 1000, 0001. `dff_d` = 10, 11, 12, 13, 10, and the `dff` `q` follows one cycle later.
- Bounded burst: `req=4'b0011`, `lock=4'b0010`, `MAX_HOLD=4` → `gnt` = 0001, then 0010 ×4, then 0001, then 0010 ×4.
- Idle hold: after `dff_d=8'h12`, set `req=0` → next cycle `dff_en=0`, `gnt=0`, `dff_d` stays 8'h12. The `dff` `q` stays 8'h12.
- Reset mid-burst: in the 2nd burst cycle of requester 1, assert `rst=0` for one cycle → next cycle `gnt=0`, `dff_en=0`, `dff_d=0`. After release with `req=4'b0011`, `gnt=4'b0001`.
- Foreign lock: requester 0 owns an unlocked grant while `lock=4'b0100`, `req=4'b0101` → `gnt` = 0001, 0100. Requester 2's lock takes effect only once it wins.
